// File: rtl/sha_axi_burst_mem.sv
// AXI4 burst slave fronting a small register-array message buffer for a SHA core.
// Independent write/read burst engines; blk_done flags a completed write reaching the last word.
module sha_axi_burst_mem #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_MEM_DEPTH        = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [7:0]                        s00_axi_awlen,
    input  logic [1:0]                        s00_axi_awburst,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wlast,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [7:0]                        s00_axi_arlen,
    input  logic [1:0]                        s00_axi_arburst,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rlast,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              blk_done
);

    localparam int unsigned BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned IW    = $clog2(C_MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

    wstate_t       wstate;
    logic [IW-1:0] widx;
    logic [IW-1:0] wmask;
    logic [1:0]    wburst;
    logic          werr;
    logic          whit;

    rstate_t       rstate;
    logic [IW-1:0] ridx;
    logic [IW-1:0] rmask;
    logic [1:0]    rburst;
    logic          rerr;
    logic [7:0]    rlen;
    logic [7:0]    rcnt;

    // Only the word-index field of the byte address is decoded; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s00_axi_awaddr, s00_axi_araddr};

    function automatic logic [IW-1:0] word_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        return addr[OFF+IW-1:OFF];
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] burst,
                                               input logic [IW-1:0] mask);
        logic [IW-1:0] inc;
        inc = idx + IW'(1);
        case (burst)
            BURST_FIXED: return idx;
            BURST_WRAP:  return (idx & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    // WRAP needs a power-of-two window of 2..16 beats that fits inside the buffer.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        logic legal;
        legal = ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) &&
                ((32'(len) + 32'd1) <= 32'(C_MEM_DEPTH));
        return (burst == BURST_WRAP) && !legal;
    endfunction

    // Write channel FSM and the storage array it owns.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate          <= W_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            blk_done        <= 1'b0;
            widx            <= '0;
            wmask           <= '0;
            wburst          <= BURST_FIXED;
            werr            <= 1'b0;
            whit            <= 1'b0;
            for (int unsigned i = 0; i < C_MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            blk_done <= 1'b0;
            case (wstate)
                W_IDLE: begin
                    s00_axi_awready <= 1'b1;
                    if (s00_axi_awvalid && s00_axi_awready) begin
                        widx            <= word_idx(s00_axi_awaddr);
                        wmask           <= IW'(s00_axi_awlen);
                        wburst          <= s00_axi_awburst;
                        werr            <= burst_err(s00_axi_awburst, s00_axi_awlen);
                        whit            <= 1'b0;
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b1;
                        wstate          <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s00_axi_wvalid && s00_axi_wready) begin
                        if (!werr) begin
                            for (int unsigned b = 0; b < BYTES; b++) begin
                                if (s00_axi_wstrb[b]) begin
                                    mem[widx][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
                                end
                            end
                            if (widx == IW'(C_MEM_DEPTH - 1)) begin
                                whit <= 1'b1;
                            end
                        end
                        widx <= next_idx(widx, wburst, wmask);
                        if (s00_axi_wlast) begin
                            s00_axi_wready <= 1'b0;
                            s00_axi_bvalid <= 1'b1;
                            s00_axi_bresp  <= werr ? RESP_SLVERR : RESP_OKAY;
                            wstate         <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s00_axi_bvalid && s00_axi_bready) begin
                        s00_axi_bvalid  <= 1'b0;
                        s00_axi_awready <= 1'b1;
                        blk_done        <= whit && !werr;
                        wstate          <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; rdata is registered from the array, so same-cycle writes are not seen.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rstate          <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
            s00_axi_rlast   <= 1'b0;
            ridx            <= '0;
            rmask           <= '0;
            rburst          <= BURST_FIXED;
            rerr            <= 1'b0;
            rlen            <= '0;
            rcnt            <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    s00_axi_arready <= 1'b1;
                    if (s00_axi_arvalid && s00_axi_arready) begin
                        ridx            <= word_idx(s00_axi_araddr);
                        rmask           <= IW'(s00_axi_arlen);
                        rburst          <= s00_axi_arburst;
                        rerr            <= burst_err(s00_axi_arburst, s00_axi_arlen);
                        rlen            <= s00_axi_arlen;
                        rcnt            <= '0;
                        s00_axi_arready <= 1'b0;
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_rlast   <= (s00_axi_arlen == 8'd0);
                        if (burst_err(s00_axi_arburst, s00_axi_arlen)) begin
                            s00_axi_rdata <= '0;
                            s00_axi_rresp <= RESP_SLVERR;
                        end else begin
                            s00_axi_rdata <= mem[word_idx(s00_axi_araddr)];
                            s00_axi_rresp <= RESP_OKAY;
                        end
                        rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rvalid && s00_axi_rready) begin
                        if (s00_axi_rlast) begin
                            s00_axi_rvalid  <= 1'b0;
                            s00_axi_rlast   <= 1'b0;
                            s00_axi_arready <= 1'b1;
                            rstate          <= R_IDLE;
                        end else begin
                            ridx          <= next_idx(ridx, rburst, rmask);
                            s00_axi_rdata <= rerr ? '0 : mem[next_idx(ridx, rburst, rmask)];
                            rcnt          <= rcnt + 8'd1;
                            s00_axi_rlast <= (8'(rcnt + 8'd1) == rlen);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_axi_burst_mem.sv
// Directed bench for sha_axi_burst_mem: burst types, strobes, stalls, error bursts, reset abort.
module tb_sha_axi_burst_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;
    logic        blk_done;

    int n_vec = 0;
    int n_err = 0;
    int blk_cnt = 0;
    logic bv_seen = 1'b0;

    logic [31:0] wbuf [0:31];
    logic [3:0]  sbuf [0:31];
    logic [31:0] rbuf [0:31];
    logic [1:0]  rrbuf [0:31];
    logic        rlbuf [0:31];
    logic [31:0] exp_d [0:31];

    sha_axi_burst_mem dut (
        .s00_axi_aclk(clk),       .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),  .s00_axi_awlen(awlen),     .s00_axi_awburst(awburst),
        .s00_axi_awvalid(awvalid),.s00_axi_awready(awready),
        .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),     .s00_axi_wlast(wlast),
        .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),   .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),  .s00_axi_arlen(arlen),     .s00_axi_arburst(arburst),
        .s00_axi_arvalid(arvalid),.s00_axi_arready(arready),
        .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),     .s00_axi_rlast(rlast),
        .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
        .blk_done(blk_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (blk_done) blk_cnt++;
        if (bvalid) bv_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input int nbeats, input int abort_at, output logic [1:0] resp);
        int cyc;
        logic got;
        resp = 2'b11;
        awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk); got = awready; @(posedge clk); #1; cyc++;
        end
        awvalid = 1'b0;
        chk("aw_handshake", 64'(got), 64'd1);
        if (!got) return;
        chk("wready_latency", 64'(wready), 64'd1);
        for (int b = 0; b < nbeats; b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            got = 1'b0; cyc = 0;
            while (!got && cyc < 50) begin
                @(negedge clk);
                if (b == abort_at) begin
                    rst_n = 1'b0; wvalid = 1'b0; wlast = 1'b0;
                    return;
                end
                got = wready; @(posedge clk); #1; cyc++;
            end
            if (!got) begin
                chk("w_handshake", 64'(got), 64'd1);
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk); got = bvalid; resp = bresp; @(posedge clk); #1; cyc++;
        end
        bready = 1'b0;
        chk("b_handshake", 64'(got), 64'd1);
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic stall, output int n);
        int cyc;
        logic got, done, held;
        logic [3:0] pat;
        logic [34:0] held_val;
        pat = 4'b1001;
        n = 0;
        araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk); got = arready; @(posedge clk); #1; cyc++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", 64'(got), 64'd1);
        if (!got) return;
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        done = 1'b0; held = 1'b0; held_val = '0; cyc = 0;
        while (!done && cyc < 200) begin
            rready = stall ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (held) begin
                chk("r_stable", 64'({rdata, rresp, rlast}), 64'(held_val));
                held = 1'b0;
            end
            if (rvalid && rready) begin
                rbuf[n] = rdata; rrbuf[n] = rresp; rlbuf[n] = rlast;
                n++;
                if (rlast || n == int'(len) + 1 || n == 32) done = 1'b1;
            end else if (rvalid) begin
                held = 1'b1;
                held_val = {rdata, rresp, rlast};
            end
            @(posedge clk); #1; cyc++;
        end
        rready = 1'b0;
        chk("r_complete", 64'(done), 64'd1);
    endtask

    task automatic expect_read(input string tag, input int n, input int want, input logic [1:0] want_resp);
        chk({tag, "_beats"}, 64'(n), 64'(want));
        for (int i = 0; i < n && i < want; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(rbuf[i]), 64'(exp_d[i]));
            chk($sformatf("%s_resp%0d", tag, i), 64'(rrbuf[i]), 64'(want_resp));
            chk($sformatf("%s_last%0d", tag, i), 64'(rlbuf[i]), 64'(i == want - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast, blk_done, rdata}), 64'd0);
    endtask

    initial begin
        logic [1:0] resp;
        int n, blk0;

        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("awready_after_reset", 64'(awready), 64'd1);
        chk("arready_after_reset", 64'(arready), 64'd1);
        @(posedge clk); #1;

        // INCR write 1..8 at word 0, read it back
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; exp_d[i] = 32'(i + 1); end
        write_burst(8'h00, 8'd7, 2'b01, 8, -1, resp);
        chk("incr_bresp", 64'(resp), 64'd0);
        read_burst(8'h00, 8'd7, 2'b01, 1'b0, n);
        expect_read("incr_rd", n, 8, 2'b00);

        // WRAP write starting at word 2: lands on words 2,3,0,1
        wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B; wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
        write_burst(8'h08, 8'd3, 2'b10, 4, -1, resp);
        chk("wrap_bresp", 64'(resp), 64'd0);
        exp_d[0] = 32'hCCCC_000C; exp_d[1] = 32'hDDDD_000D; exp_d[2] = 32'hAAAA_000A; exp_d[3] = 32'hBBBB_000B;
        read_burst(8'h00, 8'd3, 2'b01, 1'b0, n);
        expect_read("wrap_wr", n, 4, 2'b00);
        exp_d[0] = 32'hAAAA_000A; exp_d[1] = 32'hBBBB_000B; exp_d[2] = 32'hCCCC_000C; exp_d[3] = 32'hDDDD_000D;
        read_burst(8'h08, 8'd3, 2'b10, 1'b0, n);
        expect_read("wrap_rd", n, 4, 2'b00);

        // Byte strobes on word 5
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        write_burst(8'h14, 8'd0, 2'b01, 1, -1, resp);
        wbuf[0] = 32'h1234_5678; sbuf[0] = 4'b0011;
        write_burst(8'h14, 8'd0, 2'b01, 1, -1, resp);
        chk("strb_bresp", 64'(resp), 64'd0);
        exp_d[0] = 32'hFFFF_5678;
        read_burst(8'h14, 8'd0, 2'b01, 1'b0, n);
        expect_read("strb_rd", n, 1, 2'b00);
        sbuf[0] = 4'hF;

        // Stalled read of words 0..7
        exp_d[0] = 32'hCCCC_000C; exp_d[1] = 32'hDDDD_000D; exp_d[2] = 32'hAAAA_000A; exp_d[3] = 32'hBBBB_000B;
        exp_d[4] = 32'd5; exp_d[5] = 32'hFFFF_5678; exp_d[6] = 32'd7; exp_d[7] = 32'd8;
        read_burst(8'h00, 8'd7, 2'b01, 1'b1, n);
        expect_read("stall_rd", n, 8, 2'b00);

        // Illegal WRAP length: SLVERR, nothing written, error read returns zeros
        for (int i = 0; i < 3; i++) begin wbuf[i] = 32'hDEAD_BEEF; sbuf[i] = 4'hF; end
        write_burst(8'h00, 8'd2, 2'b10, 3, -1, resp);
        chk("wrap_err_bresp", 64'(resp), 64'd2);
        read_burst(8'h00, 8'd3, 2'b01, 1'b0, n);
        expect_read("wrap_err_mem", n, 4, 2'b00);
        for (int i = 0; i < 3; i++) exp_d[i] = 32'd0;
        read_burst(8'h00, 8'd2, 2'b10, 1'b0, n);
        expect_read("wrap_err_rd", n, 3, 2'b10);

        // Full-buffer INCR write produces exactly one blk_done
        chk("no_early_blk_done", 64'(blk_cnt), 64'd0);
        blk0 = blk_cnt;
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(8'h00, 8'd15, 2'b01, 16, -1, resp);
        chk("full_bresp", 64'(resp), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("blk_done_once", 64'(blk_cnt - blk0), 64'd1);

        // Early wlast after 2 of 4 beats
        wbuf[0] = 32'h77; wbuf[1] = 32'h78;
        write_burst(8'h20, 8'd3, 2'b01, 2, -1, resp);
        chk("early_wlast_bresp", 64'(resp), 64'd0);
        exp_d[0] = 32'h77; exp_d[1] = 32'h78; exp_d[2] = 32'h10A;
        read_burst(8'h20, 8'd2, 2'b01, 1'b0, n);
        expect_read("early_wlast_rd", n, 3, 2'b00);

        // FIXED write: last beat wins on word 10
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
        write_burst(8'h28, 8'd2, 2'b00, 3, -1, resp);
        exp_d[0] = 32'h33; exp_d[1] = 32'h10B;
        read_burst(8'h28, 8'd1, 2'b01, 1'b0, n);
        expect_read("fixed_rd", n, 2, 2'b00);

        // Reset during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h5555_0000 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(8'h00, 8'd7, 2'b01, 8, 2, resp);
        bv_seen = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort_reset_outputs");
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_bvalid", 64'(bv_seen), 64'd0);
        for (int i = 0; i < 16; i++) exp_d[i] = 32'd0;
        read_burst(8'h00, 8'd15, 2'b01, 1'b0, n);
        expect_read("abort_cleared", n, 16, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
